// File: rtl/seq_detect_prog_if.sv
// Bus bundle for seq_detect_prog: serial input qualification, runtime
// configuration, counter control and match/status outputs.
interface seq_detect_prog_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int LEN_W = $clog2(PAT_W + 1)
);
  // in_valid qualifies in_bit; a bit is consumed on every clk edge where
  // in_valid is high and cfg_load is low. There is no backpressure.
  logic             in_valid;
  logic             in_bit;
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_ovl;
  logic             cnt_clr;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic [LEN_W-1:0] act_len;

  modport master (
    output in_valid, in_bit, cfg_load, cfg_pattern, cfg_len, cfg_ovl, cnt_clr,
    input  match, match_cnt, act_len
  );

  modport slave (
    input  in_valid, in_bit, cfg_load, cfg_pattern, cfg_len, cfg_ovl, cnt_clr,
    output match, match_cnt, act_len
  );
endinterface

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial pattern detector with saturating match counter.
// Define SEQ_DETECT_MATCH_REG_EN to drive match from a flop (one cycle late).
module seq_detect_prog #(
  parameter int               PAT_W   = 4,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] DEF_PAT = 4'b1010,
  parameter logic             DEF_OVL = 1'b1,
  parameter int               LEN_W   = $clog2(PAT_W + 1)
) (
  input logic              clk,
  input logic              rst,
  seq_detect_prog_if.slave bus
);

  localparam int               HIST_W   = (PAT_W > 1) ? PAT_W - 1 : 1;
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_W - 1);

  logic [PAT_W-1:0]  pat_q;
  logic [LEN_W-1:0]  len_q;
  logic              ovl_q;
  logic [HIST_W-1:0] hist_q;
  logic [LEN_W-1:0]  fill_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [HIST_W:0]   win;
  logic [PAT_W-1:0]  mask;
  logic [LEN_W:0]    fill_p1;
  logic [LEN_W-1:0]  len_clamped;
  logic              fill_ok;
  logic              pat_eq;
  logic              match_comb;

  // Newest bit sits at the LSB, so the oldest bit of the active window lines
  // up with pat[len-1].
  assign win     = {hist_q, bus.in_bit};
  assign mask    = {PAT_W{1'b1}} >> (LEN_MAX - len_q);
  assign fill_p1 = {1'b0, fill_q} + (LEN_W + 1)'(1);
  assign fill_ok = (fill_p1 >= {1'b0, len_q});
  assign pat_eq  = ((win[PAT_W-1:0] & mask) == (pat_q & mask));

  assign match_comb = bus.in_valid & ~bus.cfg_load & ~rst & fill_ok & pat_eq;

  assign len_clamped = ((bus.cfg_len == '0) || (bus.cfg_len > LEN_MAX)) ?
                       LEN_MAX : bus.cfg_len;

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q  <= DEF_PAT;
      len_q  <= LEN_MAX;
      ovl_q  <= DEF_OVL;
      hist_q <= '0;
      fill_q <= '0;
    end else if (bus.cfg_load) begin
      pat_q  <= bus.cfg_pattern;
      len_q  <= len_clamped;
      ovl_q  <= bus.cfg_ovl;
      hist_q <= '0;
      fill_q <= '0;
    end else if (bus.in_valid) begin
      // Non-overlapping mode restarts from an empty window after a match.
      if (match_comb && !ovl_q) begin
        hist_q <= '0;
        fill_q <= '0;
      end else begin
        hist_q <= win[HIST_W-1:0];
        if (fill_q != FILL_MAX) begin
          fill_q <= fill_q + LEN_W'(1);
        end
      end
    end
  end

  // Clear beats a coincident match; the counter never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (bus.cnt_clr) begin
      cnt_q <= '0;
    end else if (match_comb && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.match_cnt = cnt_q;
  assign bus.act_len   = len_q;

`ifdef SEQ_DETECT_MATCH_REG_EN
  logic match_q;

  always_ff @(posedge clk) begin
    if (rst || bus.cfg_load) begin
      match_q <= 1'b0;
    end else begin
      match_q <= match_comb;
    end
  end

  assign bus.match = match_q;
`else
  assign bus.match = match_comb;
`endif

endmodule

// File: tb/tb_seq_detect_prog.sv
// Self-checking bench for seq_detect_prog: directed vector tables plus
// randomized traffic against a bit-queue reference model.
module tb_seq_detect_prog;

  localparam int PAT_W = 4;
  localparam int CNT_W = 2;
  localparam int LEN_W = 3;

  logic clk;
  logic rst;

  seq_detect_prog_if #(.PAT_W(PAT_W), .CNT_W(CNT_W), .LEN_W(LEN_W)) bus ();

  seq_detect_prog #(
    .PAT_W(PAT_W), .CNT_W(CNT_W), .DEF_PAT(4'b1010), .DEF_OVL(1'b1), .LEN_W(LEN_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters ----------------
  int tests_run = 0;
  int tests_failed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Keeps the most recent consumed bits (oldest first) since the last
  // reset, load or non-overlapping match.
  logic          mq[$];
  logic [3:0]    mpat;
  int            mlen;
  logic          movl;
  int            mcnt;
  logic          mreg;
  logic          last_m;

  function automatic logic model_match(input logic r, input logic v, input logic b,
                                       input logic ld);
    logic ok;
    logic w;
    int   n;
    if (r || ld || !v) return 1'b0;
    n = mq.size();
    if (n < mlen - 1) return 1'b0;
    ok = 1'b1;
    for (int i = 0; i < mlen; i++) begin
      w = (i == mlen - 1) ? b : mq[n - (mlen - 1) + i];
      if (w != mpat[mlen - 1 - i]) ok = 1'b0;
    end
    return ok;
  endfunction

  task automatic model_reset();
    mpat = 4'b1010;
    mlen = 4;
    movl = 1'b1;
    mq.delete();
    mcnt = 0;
    mreg = 1'b0;
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic v, input logic b, input logic ld,
                      input logic clr, input logic [3:0] p, input logic [2:0] l,
                      input logic o);
    logic mc;
    logic exp_m;
    @(negedge clk);
    rst             = r;
    bus.in_valid    = v;
    bus.in_bit      = b;
    bus.cfg_load    = ld;
    bus.cnt_clr     = clr;
    bus.cfg_pattern = p;
    bus.cfg_len     = l;
    bus.cfg_ovl     = o;
    #1;
    mc = model_match(r, v, b, ld);
`ifdef SEQ_DETECT_MATCH_REG_EN
    exp_m = mreg;
`else
    exp_m = mc;
`endif
    chk("match", 32'(bus.match), 32'(exp_m));
    chk("match_cnt", 32'(bus.match_cnt), 32'(mcnt));
    chk("act_len", 32'(bus.act_len), 32'(mlen));
    last_m = bus.match;
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      if (ld) begin
        mpat = p;
        mlen = (l == 0 || l > PAT_W) ? PAT_W : int'(l);
        movl = o;
        mq.delete();
      end else if (v) begin
        if (mc && !movl) begin
          mq.delete();
        end else begin
          mq.push_back(b);
          if (mq.size() > PAT_W - 1) void'(mq.pop_front());
        end
      end
      if (clr) mcnt = 0;
      else if (mc && mcnt < (1 << CNT_W) - 1) mcnt++;
    end
    mreg = mc;
  endtask

  task automatic idle_clr();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 3'd0, 1'b0);
  endtask

  task automatic load(input logic [3:0] p, input logic [2:0] l, input logic o);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, p, l, o);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       v;
    logic       b;
    logic       clr;
    logic       m;
    logic [1:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic v, input logic b, input logic clr,
                              input logic m, input logic [1:0] cnt);
    vec_t e;
    e.v = v; e.b = b; e.clr = clr; e.m = m; e.cnt = cnt;
    tbl.push_back(e);
  endfunction

  task automatic run_vecs(input int lo, input int hi);
    logic exp_m;
    for (int i = lo; i < hi; i++) begin
      step(1'b0, tbl[i].v, tbl[i].b, 1'b0, tbl[i].clr, 4'd0, 3'd0, 1'b0);
`ifdef SEQ_DETECT_MATCH_REG_EN
      exp_m = (i == lo) ? 1'b0 : tbl[i-1].m;
`else
      exp_m = tbl[i].m;
`endif
      chk($sformatf("tbl[%0d].match", i), 32'(last_m), 32'(exp_m));
      #1;
      chk($sformatf("tbl[%0d].cnt", i), 32'(bus.match_cnt), 32'(tbl[i].cnt));
    end
  endtask

  // ---------------- scoreboard of count history (len-1 saturation) ----------------
  logic [CNT_W-1:0] exp_q[$];

  // ---------------- main test ----------------
  int s0, s1, s2, s3, s4, s5, s6;

  initial begin
    // Table: defaults 1010 overlapping, bits 1,0,1,0,1,0
    s0 = tbl.size();
    add(1,1,0,0,0); add(1,0,0,0,0); add(1,1,0,0,0);
    add(1,0,0,1,1); add(1,1,0,0,1); add(1,0,0,1,2);
    // Table: 1010 non-overlapping, ten bits -> matches on bits 4 and 8
    s1 = tbl.size();
    add(1,1,0,0,0); add(1,0,0,0,0); add(1,1,0,0,0); add(1,0,0,1,1); add(1,1,0,0,1);
    add(1,0,0,0,1); add(1,1,0,0,1); add(1,0,0,1,2); add(1,1,0,0,2); add(1,0,0,0,2);
    // Table: 110 len 3 overlapping
    s2 = tbl.size();
    add(1,1,0,0,0); add(1,1,0,0,0); add(1,0,0,1,1);
    add(1,1,0,0,1); add(1,1,0,0,1); add(1,0,0,1,2);
    // Table: same stream with idle cycles between bits
    s3 = tbl.size();
    add(1,1,0,0,0); add(0,1,0,0,0); add(1,1,0,0,0); add(0,0,0,0,0);
    add(1,0,0,1,1); add(0,0,0,0,1); add(1,1,0,0,1); add(0,1,0,0,1);
    add(1,1,0,0,1); add(0,0,0,0,1); add(1,0,0,1,2); add(0,1,0,0,2);
    // Table: bits 1,0,1 before a reset
    s4 = tbl.size();
    add(1,1,0,0,0); add(1,0,0,0,0); add(1,1,0,0,0);
    // Table: single bit 0 after reset
    s5 = tbl.size();
    add(1,0,0,0,0);
    // Table: len 1 pattern 1, saturation then clear-with-match
    s6 = tbl.size();
    add(1,1,0,1,1); add(1,1,0,1,2); add(1,1,0,1,3); add(1,1,0,1,3);
    add(1,1,0,1,3); add(1,1,0,1,3); add(1,1,1,1,0);

    // Raw reset before any checking, model starts at its reset state
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.cfg_load = 1'b0; bus.cnt_clr = 1'b0;
    bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_ovl = 1'b0;
    model_reset();
    last_m = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_match", 32'(bus.match), 32'd0);
    chk("reset_cnt", 32'(bus.match_cnt), 32'd0);
    chk("reset_act_len", 32'(bus.act_len), 32'd4);

    run_vecs(s0, s1);

    idle_clr();
    load(4'b1010, 3'd4, 1'b0);
    run_vecs(s1, s2);

    idle_clr();
    load(4'b0110, 3'd3, 1'b1);
    run_vecs(s2, s3);
    chk("act_len_3", 32'(bus.act_len), 32'd3);

    idle_clr();
    load(4'b0110, 3'd3, 1'b1);
    run_vecs(s3, s4);

    idle_clr();
    run_vecs(s4, s5);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 1'b0);
    run_vecs(s5, s6);
    #1;
    chk("post_rst_cnt", 32'(bus.match_cnt), 32'd0);
    load(4'b1111, 3'd0, 1'b1);
    #1;
    chk("clamp_len0", 32'(bus.act_len), 32'd4);
    load(4'b1111, 3'd7, 1'b1);
    #1;
    chk("clamp_len7", 32'(bus.act_len), 32'd4);

    // cfg_load with in_valid high: bit ignored, no match, count unaffected
    load(4'b0001, 3'd1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0001, 3'd1, 1'b0);
    #1;
    chk("load_ignores_bit_cnt", 32'(bus.match_cnt), 32'd0);
    run_vecs(s6, tbl.size());

    // Randomized traffic against the model; count history kept in exp_q
    idle_clr();
    for (int i = 0; i < 3000; i++) begin
      logic r, v, b, ld, clr, o;
      logic [3:0] p;
      logic [2:0] l;
      r   = ($urandom_range(0, 99) < 2);
      ld  = ($urandom_range(0, 99) < 4);
      clr = ($urandom_range(0, 99) < 4);
      v   = ($urandom_range(0, 99) < 75);
      b   = 1'($urandom_range(0, 1));
      p   = 4'($urandom_range(0, 15));
      l   = 3'($urandom_range(0, 7));
      o   = 1'($urandom_range(0, 1));
      step(r, v, b, ld, clr, p, l, o);
      exp_q.push_back(CNT_W'(mcnt));
      #1;
      chk("rand_cnt_post", 32'(bus.match_cnt), 32'(exp_q.pop_front()));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/seq_detect_prog.md
Name: seq_detect_prog

Overview:
- Runtime-programmable serial bit-pattern detector. Parametrised successor of the fixed 4-bit Mealy overlap detector.
- Pattern value, pattern length (1..PAT_W) and overlap/non-overlap mode are loaded at runtime.
- Adds input qualification (in_valid), a saturating match counter and an optional registered match output.
- Sits after a serial deserialiser/bit-slicer and flags frame/sync words to downstream control logic.

Parameters:
- PAT_W, 4, maximum pattern length in bits (>=1).
- CNT_W, 8, width of the match counter.
- DEF_PAT, 4'b1010 (PAT_W bits), pattern loaded at reset.
- DEF_OVL, 1, overlap mode at reset (1 = overlapping matches allowed).
- LEN_W, $clog2(PAT_W+1), derived width of the length field; not to be overridden.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  qualifies in_bit; the bit is consumed only when high
- in_bit  input  1  serial data bit; the earliest-arriving bit of the pattern is the MSB of the active pattern
- cfg_load  input  1  load cfg_* fields this cycle
- cfg_pattern  input  PAT_W  pattern; only bits [len-1:0] are used
- cfg_len  input  LEN_W  active pattern length
- cfg_ovl  input  1  1 = overlapping detection, 0 = non-overlapping
- cnt_clr  input  1  synchronous clear of match_cnt
- match  output  1  pattern-complete flag (Mealy; see Optional Feature)
- match_cnt  output  CNT_W  saturating count of matches
- act_len  output  LEN_W  currently active pattern length

Behaviour:
- Reset (rst=1 at a clk edge):
  - pat=DEF_PAT, len=PAT_W, ovl=DEF_OVL.
  - Internal history register hist (PAT_W-1 bits) cleared; fill count cleared; match_cnt=0.
  - match=0 while rst is high.
  - rst has priority over all other inputs.
- Config load: on a cfg_load edge, pat, len and ovl are updated, and hist and fill are cleared.
  - cfg_len of 0 or >PAT_W is clamped to PAT_W.
  - In a cycle with cfg_load=1, match=0 and in_bit is ignored, even if in_valid=1.
  - match_cnt is not affected by cfg_load.
- Detection (combinational Mealy):
  - match = in_valid & ~cfg_load & ~rst & (fill >= len-1) & ({hist,in_bit}[len-1:0] == pat[len-1:0]).
  - The flag is asserted in the same cycle as the completing bit. Zero latency.
- History update on a clk edge with in_valid=1, cfg_load=0:
  - hist shifts left, taking in_bit at the LSB.
  - fill increments, saturating at PAT_W-1.
  - If match=1 and ovl=0: hist and fill are instead cleared, so the next match needs len fresh bits.
  - If match=1 and ovl=1: normal shift. The tail of the matched bits may start the next match.
- in_valid=0: hist, fill and match_cnt hold; match=0.
- len=1: every valid bit equal to pat[0] matches, in either mode.
- Counter:
  - match_cnt increments by 1 on each edge where match=1.
  - It saturates at all-ones and does not wrap.
  - cnt_clr clears it to 0. If cnt_clr and match coincide, the result is 0: clear wins and the match is not counted.
- act_len reflects the registered len.
- Reset mid-sequence discards all partial history. There is no match on the bit following reset until len valid bits have arrived.

Optional Feature:
- Macro SEQ_DETECT_MATCH_REG_EN.
- Defined: match is driven from a flop.
  - It asserts one cycle after the completing bit and stays high for exactly one cycle.
  - Reset value 0; cleared by rst and by cfg_load.
  - match_cnt timing is unchanged: it increments on the completing-bit edge.
- Undefined: match is the combinational Mealy output described above.

Test Plan:
- Reset defaults (1010, len 4, overlap), in_valid=1, bits 1,0,1,0,1,0 -> match high on bits 4 and 6; match_cnt=2.
- cfg_load pattern 1010, len 4, ovl=0; bits 1,0,1,0,1,0 -> match only on bit 4; match_cnt=1. Then bits 1,0,1,0 -> match on the 4th; cnt=2.
- cfg_load pattern 3'b110, len 3, ovl=1; bits 1,1,0,1,1,0 -> match on bits 3 and 6; act_len=3.
- Same stream with in_valid=0 idle cycles inserted between every bit -> identical matches, aligned to the valid cycles; match=0 on all idle cycles.
- Bits 1,0,1, then rst for one cycle, then bit 0 -> no match; cnt=0. Then cfg_len=0 load -> act_len=4 (clamped).
- CNT_W=2, len 1, pattern 1; six valid 1s -> cnt sequence 1,2,3,3,3,3. cnt_clr coincident with a match -> cnt=0. With SEQ_DETECT_MATCH_REG_EN defined, each match appears one cycle later.
